// File: rtl/instr_reorder_window.sv
// Decode-to-issue reorder window: younger ALU-class ops may issue past an oldest LOAD/STORE stalled on the LSU.
// Define INSTR_REORDER_WINDOW_PERF_EN to build the bypass_cnt_o performance counter.

package ariane_pkg;
  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [2:0]  trans_id;
    fu_t         fu;
    logic [7:0]  op;
    logic [5:0]  rs1;
    logic [5:0]  rs2;
    logic [5:0]  rd;
    logic [63:0] result;
    logic        valid;
    logic        use_imm;
    logic        use_zimm;
    logic        use_pc;
    exception_t  ex;
    logic        is_compressed;
  } scoreboard_entry_t;
endpackage

module instr_reorder_window
  import ariane_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned PERF_CNT_W = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           flush_i,
  input  logic                           debug_req_i,
  input  ariane_pkg::scoreboard_entry_t  issue_entry_i,
  input  logic                           issue_entry_valid_i,
  input  logic                           is_ctrl_flow_i,
  output logic                           issue_instr_ack_o,
  output ariane_pkg::scoreboard_entry_t  issue_entry_o,
  output logic                           issue_entry_valid_o,
  output logic                           is_ctrl_flow_o,
  input  logic                           issue_instr_ack_i,
  input  logic                           lsu_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]     fill_level_o,
  output logic [PERF_CNT_W-1:0]          bypass_cnt_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = $clog2(DEPTH);

  scoreboard_entry_t slot_q [DEPTH];
  scoreboard_entry_t slot_d [DEPTH];
  logic [DEPTH-1:0]  ctrl_q, ctrl_d;
  logic [CW-1:0]     count_q, count_d, wr_idx;
  logic [SW-1:0]     sel;
  logic [DEPTH-1:0]  elig;
  logic              not_empty, bypass_mode, enq, deq;

  function automatic logic is_mem(fu_t fu);
    return fu inside {LOAD, STORE};
  endfunction

  // An older control-flow/CSR op or a faulting op pins everything behind it.
  function automatic logic blocks_younger(scoreboard_entry_t e);
    return (e.fu inside {CTRL_FLOW, CSR}) || e.ex.valid;
  endfunction

  // Register-index hazard of younger y against older o; index 0 never conflicts.
  function automatic logic hazard(scoreboard_entry_t o, scoreboard_entry_t y);
    logic raw, war, waw;
    raw = (o.fu != STORE) && (o.rd != '0) && ((y.rs1 == o.rd) || (y.rs2 == o.rd));
    war = (y.rd != '0) && ((y.rd == o.rs1) || ((o.fu != LOAD) && (y.rd == o.rs2)));
    waw = (o.fu != STORE) && (y.rd != '0) && (y.rd == o.rd);
    return raw || war || waw;
  endfunction

  assign not_empty           = (count_q != '0);
  assign issue_instr_ack_o   = (count_q < CW'(DEPTH));
  assign issue_entry_valid_o = not_empty;
  assign issue_entry_o       = not_empty ? slot_q[sel] : '0;
  assign is_ctrl_flow_o      = not_empty & ctrl_q[sel];
  assign fill_level_o        = count_q;

  assign enq    = issue_entry_valid_i & issue_instr_ack_o & ~flush_i;
  assign deq    = not_empty & issue_instr_ack_i & ~flush_i;
  assign wr_idx = count_q - CW'(deq);

  always_comb begin
    elig = '0;
    for (int unsigned j = 1; j < DEPTH; j++) begin
      elig[j] = (CW'(j) < count_q) && !is_mem(slot_q[j].fu) &&
                !(slot_q[j].fu inside {CTRL_FLOW, CSR}) && !slot_q[j].ex.valid;
      for (int unsigned i = 0; i < j; i++) begin
        if (blocks_younger(slot_q[i]) || hazard(slot_q[i], slot_q[j])) elig[j] = 1'b0;
      end
    end
  end

  // Downward scan so the lowest eligible index wins.
  always_comb begin
    bypass_mode = not_empty && is_mem(slot_q[0].fu) && !lsu_ready_i && !debug_req_i;
    sel = '0;
    if (bypass_mode) begin
      for (int unsigned j = DEPTH - 1; j >= 1; j--) begin
        if (elig[j]) sel = SW'(j);
      end
    end
  end

  // Collapse the dequeued slot first, then append at the post-collapse tail.
  always_comb begin
    slot_d = slot_q;
    ctrl_d = ctrl_q;
    if (deq) begin
      for (int unsigned k = 0; k < DEPTH - 1; k++) begin
        if (SW'(k) >= sel) begin
          slot_d[k] = slot_q[k+1];
          ctrl_d[k] = ctrl_q[k+1];
        end
      end
    end
    if (enq) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (CW'(k) == wr_idx) begin
          slot_d[k] = issue_entry_i;
          ctrl_d[k] = is_ctrl_flow_i;
        end
      end
    end
    count_d = flush_i ? '0 : (count_q + CW'(enq) - CW'(deq));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      ctrl_q  <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) slot_q[k] <= '0;
    end else begin
      count_q <= count_d;
      ctrl_q  <= ctrl_d;
      slot_q  <= slot_d;
    end
  end

`ifdef INSTR_REORDER_WINDOW_PERF_EN
  logic [PERF_CNT_W-1:0] bypass_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bypass_cnt_q <= '0;
    end else if (deq && (sel != '0)) begin
      bypass_cnt_q <= bypass_cnt_q + PERF_CNT_W'(1);
    end
  end

  assign bypass_cnt_o = bypass_cnt_q;
`else
  assign bypass_cnt_o = '0;
`endif

endmodule

// File: tb/tb_instr_reorder_window.sv
// Directed self-checking bench for instr_reorder_window (DEPTH=4).
module tb_instr_reorder_window;
  import ariane_pkg::*;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic flush = 1'b0;
  logic debug_req = 1'b0;
  logic entry_valid = 1'b0;
  logic ctrl_in = 1'b0;
  logic ack_in = 1'b0;
  logic lsu_ready = 1'b1;
  scoreboard_entry_t entry_in = '0;
  scoreboard_entry_t entry_out;
  scoreboard_entry_t zero_e = '0;
  logic entry_valid_out, ctrl_out, ack_out;
  logic [2:0] fill;
  logic [31:0] bypass_cnt;
  int checks = 0;
  int fails = 0;
  int exp_byp;

  instr_reorder_window #(.DEPTH(4), .PERF_CNT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush), .debug_req_i(debug_req),
    .issue_entry_i(entry_in), .issue_entry_valid_i(entry_valid), .is_ctrl_flow_i(ctrl_in),
    .issue_instr_ack_o(ack_out), .issue_entry_o(entry_out), .issue_entry_valid_o(entry_valid_out),
    .is_ctrl_flow_o(ctrl_out), .issue_instr_ack_i(ack_in), .lsu_ready_i(lsu_ready),
    .fill_level_o(fill), .bypass_cnt_o(bypass_cnt)
  );

  always #5 clk = ~clk;

  function automatic scoreboard_entry_t mk(input int unsigned pc, input fu_t fu,
                                           input int unsigned rd, input int unsigned rs1,
                                           input int unsigned rs2);
    scoreboard_entry_t e;
    e = '0;
    e.pc = 64'(pc);
    e.fu = fu;
    e.rd = 6'(rd);
    e.rs1 = 6'(rs1);
    e.rs2 = 6'(rs2);
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_ni = 1'b0; flush = 1'b0; debug_req = 1'b0; entry_valid = 1'b0;
    ctrl_in = 1'b0; ack_in = 1'b0; lsu_ready = 1'b1;
    #2;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic push(input scoreboard_entry_t e, input logic c);
    entry_in = e; ctrl_in = c; entry_valid = 1'b1;
    tick();
    entry_valid = 1'b0; ctrl_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_ni = 1'b0;
    #3;
    checks++; if (ack_out !== 1'b1) begin fails++; $display("FAIL reset_ack: got %b want 1", ack_out); end
    checks++; if (entry_valid_out !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", entry_valid_out); end
    checks++; if (fill !== 3'd0) begin fails++; $display("FAIL reset_fill: got %0d want 0", fill); end
    checks++; if (bypass_cnt !== 32'd0) begin fails++; $display("FAIL reset_bypass: got %0d want 0", bypass_cnt); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_in_order;
    scoreboard_entry_t ea [4];
    do_reset();
    ack_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ea[k] = mk(100 + k, ALU, 10 + k, 1, 2);
      entry_in = ea[k]; entry_valid = 1'b1;
      #1;
      checks++; if (ack_out !== 1'b1) begin fails++; $display("FAIL inorder_ack%0d: got %b want 1", k, ack_out); end
      if (k == 0) begin
        checks++; if (entry_valid_out !== 1'b0) begin fails++; $display("FAIL inorder_latency: got valid %b want 0", entry_valid_out); end
      end else begin
        checks++; if (entry_out !== ea[k-1] || entry_valid_out !== 1'b1) begin fails++; $display("FAIL inorder_out%0d: got pc=%0d want pc=%0d", k, entry_out.pc, ea[k-1].pc); end
        checks++; if (fill !== 3'd1) begin fails++; $display("FAIL inorder_fill%0d: got %0d want 1", k, fill); end
      end
      tick();
    end
    entry_valid = 1'b0;
    #1;
    checks++; if (entry_out !== ea[3]) begin fails++; $display("FAIL inorder_last: got pc=%0d want pc=103", entry_out.pc); end
    tick();
    checks++; if (entry_valid_out !== 1'b0 || fill !== 3'd0) begin fails++; $display("FAIL inorder_drain: got valid %b fill %0d want 0 0", entry_valid_out, fill); end
  endtask

  task automatic test_bypass;
    scoreboard_entry_t ld, add;
    do_reset();
`ifdef INSTR_REORDER_WINDOW_PERF_EN
    exp_byp = 1;
`else
    exp_byp = 0;
`endif
    lsu_ready = 1'b0;
    ld = mk(200, LOAD, 5, 1, 0);
    add = mk(201, ALU, 6, 2, 3);
    push(ld, 1'b0);
    push(add, 1'b0);
    checks++; if (entry_out !== add || fill !== 3'd2) begin fails++; $display("FAIL bypass_sel: got pc=%0d fill %0d want pc=201 fill 2", entry_out.pc, fill); end
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if (bypass_cnt !== 32'(exp_byp)) begin fails++; $display("FAIL bypass_cnt: got %0d want %0d", bypass_cnt, exp_byp); end
    checks++; if (entry_out !== ld || fill !== 3'd1) begin fails++; $display("FAIL bypass_load_waits: got pc=%0d fill %0d want pc=200 fill 1", entry_out.pc, fill); end
    lsu_ready = 1'b1; ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    checks++; if (fill !== 3'd0 || bypass_cnt !== 32'(exp_byp)) begin fails++; $display("FAIL bypass_load_issued: got fill %0d cnt %0d want 0 %0d", fill, bypass_cnt, exp_byp); end
  endtask

  task automatic test_raw_hazard;
    scoreboard_entry_t ld, add;
    do_reset();
    lsu_ready = 1'b0;
    ld = mk(300, LOAD, 5, 1, 0);
    add = mk(301, ALU, 6, 5, 2);
    push(ld, 1'b0);
    push(add, 1'b0);
    checks++; if (entry_out !== ld) begin fails++; $display("FAIL raw_hold: got pc=%0d want pc=300", entry_out.pc); end
    tick();
    checks++; if (entry_out !== ld || fill !== 3'd2) begin fails++; $display("FAIL raw_hold2: got pc=%0d fill %0d want pc=300 fill 2", entry_out.pc, fill); end
    lsu_ready = 1'b1; ack_in = 1'b1;
    tick();
    checks++; if (entry_out !== add) begin fails++; $display("FAIL raw_order: got pc=%0d want pc=301", entry_out.pc); end
    tick();
    ack_in = 1'b0;
    checks++; if (bypass_cnt !== 32'd0 || fill !== 3'd0) begin fails++; $display("FAIL raw_cnt: got cnt %0d fill %0d want 0 0", bypass_cnt, fill); end
  endtask

  task automatic test_hazard_rules;
    scoreboard_entry_t o [6];
    scoreboard_entry_t y [6];
    scoreboard_entry_t ex;
    logic byp [6];
    o[0] = mk(500, LOAD, 5, 1, 7);  y[0] = mk(501, ALU, 7, 2, 3);  byp[0] = 1'b1;
    o[1] = mk(510, STORE, 0, 1, 7); y[1] = mk(511, ALU, 7, 2, 3);  byp[1] = 1'b0;
    o[2] = mk(520, STORE, 6, 1, 2); y[2] = mk(521, ALU, 9, 6, 3);  byp[2] = 1'b1;
    o[3] = mk(530, LOAD, 0, 1, 0);  y[3] = mk(531, ALU, 6, 0, 2);  byp[3] = 1'b1;
    o[4] = mk(540, LOAD, 5, 1, 0);  y[4] = mk(541, MULT, 5, 2, 3); byp[4] = 1'b0;
    o[5] = mk(550, LOAD, 5, 1, 0);  y[5] = mk(551, ALU, 6, 2, 3);  byp[5] = 1'b0;
    y[5].ex.valid = 1'b1;
    for (int r = 0; r < 6; r++) begin
      do_reset();
      lsu_ready = 1'b0;
      push(o[r], 1'b0);
      push(y[r], 1'b0);
      ex = byp[r] ? y[r] : o[r];
      checks++; if (entry_out !== ex) begin fails++; $display("FAIL hazard_row%0d: got pc=%0d want pc=%0d", r, entry_out.pc, ex.pc); end
    end
  endtask

  task automatic test_skip_mem;
    scoreboard_entry_t ld, ld2, add;
    do_reset();
    lsu_ready = 1'b0;
    ld = mk(600, LOAD, 5, 1, 0);
    ld2 = mk(601, LOAD, 6, 2, 0);
    add = mk(602, ALU, 7, 3, 4);
    push(ld, 1'b0);
    push(ld2, 1'b0);
    push(add, 1'b0);
    checks++; if (entry_out !== add) begin fails++; $display("FAIL skip_mem: got pc=%0d want pc=602", entry_out.pc); end
  endtask

  task automatic test_ctrl_flow;
    scoreboard_entry_t st, beq, add;
    do_reset();
    lsu_ready = 1'b0;
    st = mk(400, STORE, 0, 1, 2);
    beq = mk(401, CTRL_FLOW, 0, 3, 4);
    add = mk(402, ALU, 7, 8, 9);
    push(st, 1'b0);
    push(beq, 1'b1);
    push(add, 1'b0);
    checks++; if (entry_out !== st || ctrl_out !== 1'b0) begin fails++; $display("FAIL ctrl_first: got pc=%0d ctrl %b want pc=400 ctrl 0", entry_out.pc, ctrl_out); end
    ack_in = 1'b1;
    tick();
    checks++; if (entry_out !== beq || ctrl_out !== 1'b1) begin fails++; $display("FAIL ctrl_second: got pc=%0d ctrl %b want pc=401 ctrl 1", entry_out.pc, ctrl_out); end
    tick();
    checks++; if (entry_out !== add || ctrl_out !== 1'b0) begin fails++; $display("FAIL ctrl_third: got pc=%0d ctrl %b want pc=402 ctrl 0", entry_out.pc, ctrl_out); end
    tick();
    ack_in = 1'b0;
    checks++; if (entry_valid_out !== 1'b0 || bypass_cnt !== 32'd0) begin fails++; $display("FAIL ctrl_drain: got valid %b cnt %0d want 0 0", entry_valid_out, bypass_cnt); end
  endtask

  task automatic test_full;
    scoreboard_entry_t ea [5];
    do_reset();
    for (int k = 0; k < 5; k++) ea[k] = mk(700 + k, ALU, 10 + k, 1, 2);
    for (int k = 0; k < 4; k++) push(ea[k], 1'b0);
    checks++; if (ack_out !== 1'b0 || fill !== 3'd4) begin fails++; $display("FAIL full_state: got ack %b fill %0d want 0 4", ack_out, fill); end
    entry_in = ea[4]; entry_valid = 1'b1; ack_in = 1'b1;
    #1;
    checks++; if (ack_out !== 1'b0) begin fails++; $display("FAIL full_ack_same_cycle: got %b want 0", ack_out); end
    tick();
    entry_valid = 1'b0;
    checks++; if (fill !== 3'd3 || entry_out !== ea[1]) begin fails++; $display("FAIL full_after: got fill %0d pc=%0d want 3 pc=701", fill, entry_out.pc); end
    tick();
    checks++; if (entry_out !== ea[2]) begin fails++; $display("FAIL full_drain2: got pc=%0d want pc=702", entry_out.pc); end
    tick();
    checks++; if (entry_out !== ea[3]) begin fails++; $display("FAIL full_drain3: got pc=%0d want pc=703", entry_out.pc); end
    tick();
    ack_in = 1'b0;
    checks++; if (fill !== 3'd0 || ack_out !== 1'b1) begin fails++; $display("FAIL full_empty: got fill %0d ack %b want 0 1", fill, ack_out); end
  endtask

  task automatic test_flush;
    do_reset();
    for (int k = 0; k < 3; k++) push(mk(800 + k, ALU, 10 + k, 1, 2), 1'b0);
    flush = 1'b1; entry_in = mk(809, ALU, 20, 1, 2); entry_valid = 1'b1; ack_in = 1'b1;
    tick();
    flush = 1'b0; entry_valid = 1'b0; ack_in = 1'b0;
    checks++; if (fill !== 3'd0 || entry_valid_out !== 1'b0) begin fails++; $display("FAIL flush_empty: got fill %0d valid %b want 0 0", fill, entry_valid_out); end
    checks++; if (entry_out !== zero_e) begin fails++; $display("FAIL flush_entry_zero: got pc=%0d fu=%0d want all zero", entry_out.pc, entry_out.fu); end
    tick();
    checks++; if (fill !== 3'd0 || ack_out !== 1'b1) begin fails++; $display("FAIL flush_stays: got fill %0d ack %b want 0 1", fill, ack_out); end
  endtask

  task automatic test_debug;
    scoreboard_entry_t ld, add;
    do_reset();
    debug_req = 1'b1; lsu_ready = 1'b0;
    ld = mk(900, LOAD, 5, 1, 0);
    add = mk(901, ALU, 6, 2, 3);
    push(ld, 1'b0);
    push(add, 1'b0);
    checks++; if (entry_out !== ld) begin fails++; $display("FAIL debug_first: got pc=%0d want pc=900", entry_out.pc); end
    ack_in = 1'b1;
    tick();
    checks++; if (entry_out !== add) begin fails++; $display("FAIL debug_second: got pc=%0d want pc=901", entry_out.pc); end
    tick();
    ack_in = 1'b0; debug_req = 1'b0;
    checks++; if (bypass_cnt !== 32'd0 || fill !== 3'd0) begin fails++; $display("FAIL debug_cnt: got cnt %0d fill %0d want 0 0", bypass_cnt, fill); end
  endtask

  task automatic test_async_reset;
    do_reset();
    push(mk(950, ALU, 5, 1, 2), 1'b0);
    push(mk(951, ALU, 6, 1, 2), 1'b0);
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (fill !== 3'd0 || entry_valid_out !== 1'b0 || ack_out !== 1'b1) begin fails++; $display("FAIL async_reset: got fill %0d valid %b ack %b want 0 0 1", fill, entry_valid_out, ack_out); end
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_bypass();
    test_raw_hazard();
    test_hazard_rules();
    test_skip_mem();
    test_ctrl_flow();
    test_full();
    test_flush();
    test_debug();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
